// File: rtl/video_stream_source_pkg.sv
// Shared video-timing definitions: default raster, pixel width, FSM states.
package video_stream_source_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_TOTAL  = 525;
    localparam int DEF_VS_LINES = 2;
    localparam int DEF_V_START  = 35;
    localparam int DEF_CLK_DIV  = 2;

    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_stream_source_if.sv
// Pixel stream bundle: frame sync, slot strobe, valid qualifier and RGB data.
interface video_stream_source_if
    import video_stream_source_pkg::*;
;
    logic             pos_image_vsync;
    logic             pos_image_clken;
    logic             pos_data_valid;
    logic [PIX_W-1:0] pos_image_data;

    modport master (
        output pos_image_vsync,
        output pos_image_clken,
        output pos_data_valid,
        output pos_image_data
    );

    modport slave (
        input pos_image_vsync,
        input pos_image_clken,
        input pos_data_valid,
        input pos_image_data
    );
endinterface

// File: rtl/video_stream_source_raster_counter.sv
// Pixel-slot divider plus horizontal/vertical raster counters with decoded flags.
module raster_counter
    import video_stream_source_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int V_START  = DEF_V_START,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic s,
    output logic h_last,
    output logic v_last,
    output logic active,
    output logic vsync_next
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam int H_W   = cnt_w(H_TOTAL);
    localparam int V_W   = cnt_w(V_TOTAL);

    logic [DIV_W-1:0] div_reg;
    logic [H_W-1:0]   h_reg;
    logic [V_W-1:0]   v_reg;

    assign s          = run && (div_reg == DIV_W'(CLK_DIV - 1));
    assign h_last     = (h_reg == H_W'(H_TOTAL - 1));
    assign v_last     = (v_reg == V_W'(V_TOTAL - 1));
    // Upper line bound is inclusive so it never needs a value of V_TOTAL.
    assign active     = (v_reg >= V_W'(V_START)) &&
                        (v_reg <= V_W'(V_START + V_ACTIVE - 1)) &&
                        (h_reg <  H_W'(H_ACTIVE));
    assign vsync_next = (v_reg < V_W'(VS_LINES));

    // Counters sit at zero whenever not running, so every frame starts at h=v=div=0.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else if (s) begin
            div_reg <= '0;
            if (h_last) begin
                h_reg <= '0;
                v_reg <= v_last ? '0 : v_reg + V_W'(1);
            end else begin
                h_reg <= h_reg + H_W'(1);
            end
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/video_stream_source.sv
// Frame-buffer playback source: pops an FWFT FIFO into a fixed raster pixel stream.
module video_stream_source
    import video_stream_source_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int V_START  = DEF_V_START,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [PIX_W-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 frame_done,
    output logic                 underflow,
    video_stream_source_if.master vid
);

    state_t state_reg, state_next;

    logic run, s, h_last, v_last, active, vsync_next;
    logic frame_end, frame_start, pix_slot;

    logic             vsync_reg, clken_reg, valid_reg, frame_done_reg, underflow_reg;
    logic [PIX_W-1:0] data_reg;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL),
        .VS_LINES (VS_LINES),
        .V_START  (V_START),
        .CLK_DIV  (CLK_DIV)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .s          (s),
        .h_last     (h_last),
        .v_last     (v_last),
        .active     (active),
        .vsync_next (vsync_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next state: enable is only looked at in IDLE and on the final slot of a frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (enable) state_next = ST_RUN;
            ST_RUN:   if (frame_end && !enable) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Decoded controls; the FIFO pop is combinational and suppressed during reset.
    always_comb begin
        run         = (state_reg == ST_RUN);
        frame_end   = run && s && h_last && v_last;
        frame_start = ((state_reg == ST_IDLE) || frame_end) && enable;
        pix_slot    = run && s && active;
        fifo_rd_en  = pix_slot && !fifo_empty && !rst;
    end

    // Registered stream outputs; an empty FIFO still yields a valid (black) pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_reg      <= 1'b0;
            clken_reg      <= 1'b0;
            valid_reg      <= 1'b0;
            data_reg       <= '0;
            frame_done_reg <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            vsync_reg      <= run && vsync_next;
            clken_reg      <= run && s;
            valid_reg      <= pix_slot;
            data_reg       <= (pix_slot && !fifo_empty) ? fifo_dout : '0;
            frame_done_reg <= frame_end;
            // Clear lands on the first cycle of a frame, before any active slot can set it.
            if (frame_start)
                underflow_reg <= 1'b0;
            else if (pix_slot && fifo_empty)
                underflow_reg <= 1'b1;
        end
    end

    assign vid.pos_image_vsync = vsync_reg;
    assign vid.pos_image_clken = clken_reg;
    assign vid.pos_data_valid  = valid_reg;
    assign vid.pos_image_data  = data_reg;
    assign frame_done          = frame_done_reg;
    assign underflow           = underflow_reg;

endmodule

// File: tb/tb_video_stream_source.sv
// Directed bench: tiny raster at CLK_DIV=2 (instance a) and CLK_DIV=1 (instance b).
module tb_video_stream_source;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable_a = 1'b0;
    logic enable_b = 1'b0;

    always #5 clk = ~clk;

    // Instance a: FIFO model with preloadable storage.
    logic [23:0] mem_a [0:63];
    int          wr_a = 0;
    int          rd_a = 0;
    logic        fifo_empty_a, rd_en_a, fd_a, uf_a;
    logic [23:0] fifo_dout_a;
    assign fifo_empty_a = (rd_a == wr_a);
    assign fifo_dout_a  = mem_a[rd_a[5:0]];

    // Instance b: never-empty FIFO whose head is the running pop count.
    int          pops_b = 0;
    logic        fifo_empty_b, rd_en_b, fd_b, uf_b;
    logic [23:0] fifo_dout_b;
    assign fifo_empty_b = 1'b0;
    assign fifo_dout_b  = {8'h00, pops_b[15:0]};

    video_stream_source_if vid_a ();
    video_stream_source_if vid_b ();

    video_stream_source #(
        .H_ACTIVE(4), .H_TOTAL(6), .V_ACTIVE(3), .V_TOTAL(6),
        .VS_LINES(1), .V_START(2), .CLK_DIV(2)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a),
        .fifo_dout(fifo_dout_a), .fifo_empty(fifo_empty_a), .fifo_rd_en(rd_en_a),
        .frame_done(fd_a), .underflow(uf_a), .vid(vid_a)
    );

    video_stream_source #(
        .H_ACTIVE(4), .H_TOTAL(6), .V_ACTIVE(3), .V_TOTAL(6),
        .VS_LINES(1), .V_START(2), .CLK_DIV(1)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b),
        .fifo_dout(fifo_dout_b), .fifo_empty(fifo_empty_b), .fifo_rd_en(rd_en_b),
        .frame_done(fd_b), .underflow(uf_b), .vid(vid_b)
    );

    // FIFO pops happen on the clock edge that sees the read enable.
    always @(posedge clk) begin
        if (rd_en_a) rd_a   <= rd_a + 1;
        if (rd_en_b) pops_b <= pops_b + 1;
    end

    // Monitor state, sampled on the falling edge.
    int          cyc = 0;
    int          clk_a_n = 0, pix_n = 0, vs_n = 0, vs_rise = 0, fd_n = 0, fd_cyc = 0, viol_a = 0;
    logic        vs_prev = 1'b0;
    logic [23:0] pix_log [0:63];
    logic        uf_log  [0:63];
    int          clk_b_n = 0, fd_b_n = 0;
    int          fd_b_cyc [0:3];
    int          pops_b_at [0:3];
    int          clk_b_at [0:3];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (vid_a.pos_image_clken) clk_a_n <= clk_a_n + 1;
        if (vid_a.pos_data_valid && pix_n < 64) begin
            pix_log[pix_n] <= vid_a.pos_image_data;
            uf_log[pix_n]  <= uf_a;
            pix_n          <= pix_n + 1;
        end
        if (vid_a.pos_image_vsync) vs_n <= vs_n + 1;
        if (vid_a.pos_image_vsync && !vs_prev) vs_rise <= cyc;
        vs_prev <= vid_a.pos_image_vsync;
        if (fd_a) begin
            fd_n   <= fd_n + 1;
            fd_cyc <= cyc;
        end
        if (rd_en_a && fifo_empty_a) viol_a <= viol_a + 1;
        if (vid_b.pos_image_clken) clk_b_n <= clk_b_n + 1;
        if (fd_b && fd_b_n < 4) begin
            fd_b_cyc[fd_b_n]  <= cyc;
            pops_b_at[fd_b_n] <= pops_b;
            clk_b_at[fd_b_n]  <= clk_b_n;
            fd_b_n            <= fd_b_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fd_a(input int target, input int budget);
        int n = budget;
        while (fd_n < target && n > 0) begin
            step();
            n--;
        end
        if (fd_n < target) check_eq("timeout_fd_a", 32'(fd_n), 32'(target));
    endtask

    task automatic wait_pix_a(input int base, input int budget);
        int n = budget;
        while (pix_n == base && n > 0) begin
            step();
            n--;
        end
        if (pix_n == base) check_eq("timeout_pix_a", 32'(pix_n), 32'(base + 1));
    endtask

    task automatic check_quiet_a(input string tag);
        check_eq({tag, "_vsync"}, 32'(vid_a.pos_image_vsync), 32'd0);
        check_eq({tag, "_clken"}, 32'(vid_a.pos_image_clken), 32'd0);
        check_eq({tag, "_valid"}, 32'(vid_a.pos_data_valid), 32'd0);
        check_eq({tag, "_data"},  32'(vid_a.pos_image_data), 32'd0);
        check_eq({tag, "_fdone"}, 32'(fd_a), 32'd0);
    endtask

    initial begin
        int b, pb, vb, cb, nb;
        // Reset state
        for (int i = 0; i < 12; i++) mem_a[i] = 24'(i + 1);
        for (int i = 0; i < 5; i++)  mem_a[12 + i] = 24'(13 + i);
        wr_a = 17;
        repeat (3) step();
        check_quiet_a("rst");
        check_eq("rst_underflow", 32'(uf_a), 32'd0);
        check_eq("rst_rd_en", 32'(rd_en_a), 32'd0);
        rst = 1'b0;
        step();
        check_eq("idle_clken", 32'(vid_a.pos_image_clken), 32'd0);

        // Frame 1: 12 words available, expect them in order
        b = pix_n; vb = vs_n;
        enable_a = 1'b1;
        wait_fd_a(1, 200);
        check_eq("f1_pix_count", 32'(pix_n - b), 32'd12);
        for (int i = 0; i < 12; i++) check_eq("f1_pix", 32'(pix_log[b + i]), 32'(i + 1));
        check_eq("f1_vsync_cycles", 32'(vs_n - vb), 32'd12);
        check_eq("f1_frame_len", 32'(fd_cyc - vs_rise + 1), 32'd72);
        check_eq("f1_pops", 32'(rd_a), 32'd12);
        check_eq("f1_underflow", 32'(uf_a), 32'd0);

        // Frame 2 follows seamlessly with 5 words; enable drops mid-frame
        b = pix_n;
        repeat (10) step();
        enable_a = 1'b0;
        wait_fd_a(2, 200);
        check_eq("f2_pix_count", 32'(pix_n - b), 32'd12);
        for (int i = 0; i < 12; i++)
            check_eq("f2_pix", 32'(pix_log[b + i]), (i < 5) ? 32'(13 + i) : 32'd0);
        check_eq("f2_uf_pix5", 32'(uf_log[b + 4]), 32'd0);
        check_eq("f2_uf_pix6", 32'(uf_log[b + 5]), 32'd1);
        check_eq("f2_uf_pix12", 32'(uf_log[b + 11]), 32'd1);
        check_eq("f2_pops", 32'(rd_a), 32'd17);
        check_eq("rd_while_empty", 32'(viol_a), 32'd0);
        check_eq("f2_fd_underflow", 32'(uf_a), 32'd1);
        step();
        check_quiet_a("idle");
        cb = clk_a_n;
        repeat (20) step();
        check_eq("idle_no_clken", 32'(clk_a_n - cb), 32'd0);
        check_eq("idle_uf_sticky", 32'(uf_a), 32'd1);

        // Frame 3: underflow clears at frame start, then reset during an active line
        for (int i = 0; i < 12; i++) mem_a[17 + i] = 24'(8'hA0 + i);
        wr_a = 29;
        enable_a = 1'b1;
        step();
        check_eq("f3_uf_cleared", 32'(uf_a), 32'd0);
        b = pix_n;
        wait_pix_a(b, 200);
        check_eq("f3_first_pix", 32'(pix_log[b]), 32'hA0);
        step();
        rst = 1'b1;
        #1;
        check_eq("rst_cycle_rd_en", 32'(rd_en_a), 32'd0);
        pb = rd_a;
        step();
        check_eq("rst_no_pop", 32'(rd_a), 32'(pb));
        check_quiet_a("midrst");
        rst = 1'b0;
        step();
        step();
        check_eq("restart_vsync", 32'(vid_a.pos_image_vsync), 32'd1);
        b = pix_n;
        wait_pix_a(b, 200);
        check_eq("restart_pix", 32'(pix_log[b]), 32'hA1);
        enable_a = 1'b0;

        // Instance b: CLK_DIV=1, two back-to-back frames
        nb = fd_b_n;
        enable_b = 1'b1;
        for (int n = 0; n < 300 && fd_b_n < nb + 2; n++) step();
        enable_b = 1'b0;
        if (fd_b_n < nb + 2) begin
            check_eq("timeout_fd_b", 32'(fd_b_n), 32'(nb + 2));
        end else begin
            check_eq("b_f1_pops", 32'(pops_b_at[nb]), 32'd12);
            check_eq("b_f2_pops", 32'(pops_b_at[nb + 1] - pops_b_at[nb]), 32'd12);
            check_eq("b_frame_gap", 32'(fd_b_cyc[nb + 1] - fd_b_cyc[nb]), 32'd36);
            check_eq("b_clken_cont", 32'(clk_b_at[nb + 1] - clk_b_at[nb]), 32'd36);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_stream_source.md
# video_stream_source

Generates the pixel stream that feeds the image-processing chain: `vsync` / `clken` / `data_valid` / 24-bit RGB.

- Reads pixels from a first-word-fall-through frame-buffer FIFO.
- Frames them with rigid, parameterised raster timing.
- It is the transmitter for the stream consumed by the RGB→YCbCr→binarisation path, and replaces the CMOS sensor for frame-buffer playback and bench stimulus.

## Interface

Parameters:
- `H_ACTIVE`, 640, active pixel slots per line
- `H_TOTAL`, 800, pixel slots per line (≥ `H_ACTIVE`+1)
- `V_ACTIVE`, 480, active lines per frame
- `V_TOTAL`, 525, lines per frame
- `VS_LINES`, 2, lines with `vsync` high, starting at line 0
- `V_START`, 35, first active line (`VS_LINES` ≤ `V_START`; `V_START`+`V_ACTIVE` ≤ `V_TOTAL`)
- `CLK_DIV`, 2, `clk` cycles per pixel slot (≥ 1)

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: request streaming; sampled at frame boundaries only.
- `fifo_dout` in 24: FWFT head word, RGB888.
- `fifo_empty` in 1: FIFO empty.
- `fifo_rd_en` out 1: pop head word.
- `pos_image_vsync` out 1: frame sync.
- `pos_image_clken` out 1: one-cycle pulse per pixel slot.
- `pos_data_valid` out 1: active pixel, qualified by `clken`.
- `pos_image_data` out 24: pixel; 0 when not valid.
- `frame_done` out 1: one-cycle pulse after the last slot of a frame.
- `underflow` out 1: sticky; an active slot found the FIFO empty. Cleared by `rst` or at the start of each new frame.

## Operation

State machine with three states:
- **IDLE**: all outputs 0, counters held at 0.
  - `enable`=1 → **RUN** at `h`=0, `v`=0, `div`=0.
- **RUN**: counters advance.
  - `div` counts 0..`CLK_DIV`-1; the slot strobe `s` is `div`==`CLK_DIV`-1.
  - On `s`: `h` increments and wraps at `H_TOTAL`-1 to 0. On that wrap, `v` increments and wraps at `V_TOTAL`-1 to 0.
  - At the slot `h`=`H_TOTAL`-1, `v`=`V_TOTAL`-1, with `s`, `frame_done` fires:
    - If `enable`=1, the next frame starts seamlessly.
    - If `enable`=0, go to **DRAIN**.
- **DRAIN**: one cycle; outputs forced to 0; then **IDLE**.

Signal definitions:
- Active slot: `v` in [`V_START`, `V_START`+`V_ACTIVE`-1] and `h` < `H_ACTIVE`.
- `vsync_next` = (`v` < `VS_LINES`).
- On `s` in an active slot:
  - `fifo_rd_en`=1 iff `fifo_empty`=0.
  - Output data = `fifo_dout` if not empty, else 24'h000000 with `underflow` set. `pos_data_valid` is still 1, so raster timing is never stretched.
- Outside `s`, `fifo_rd_en`=0.
- `enable` dropping mid-frame has no effect until the frame boundary.

## Timing

- `fifo_rd_en` is combinational from counters and `fifo_empty`: asserted in the slot's `s` cycle.
- Stream outputs are registered and appear 1 cycle after `s`.
  - `pos_image_clken` is high for exactly that 1 cycle.
  - `pos_data_valid` and `pos_image_data` are valid only in that cycle; 0 otherwise.
  - `pos_image_vsync` is registered from `vsync_next` every cycle and holds level between pulses.
- With `CLK_DIV`=1, `clken` is continuously high in **RUN**.
- `frame_done` is registered and coincides with the last slot's `clken`.
- Reset: all outputs 0, state **IDLE**, counters 0, `underflow` 0. `rst` mid-frame aborts immediately; no FIFO pops occur in the reset cycle.
- Simultaneous events:
  - Frame end plus `enable`=1 → next frame's line 0 begins with no gap cycle.
  - An underflow in the first active slot of a frame → `underflow` reads 1. The frame-start clear takes place at `h`=0, `v`=0, before any active slot.

## Structure

- Shared video-timing package: default raster constants (640×480 @ 800×525), pixel width 24, FSM state enum (**IDLE**, **RUN**, **DRAIN**).
- One sub-module: `raster_counter`. It holds `div`, `h` and `v`, and outputs `s`, `h_last`, `v_last`, `active` and `vsync_next`.
- The FSM and output registers live in the top.

## Test plan

1. Tiny raster (`H_ACTIVE`=4, `H_TOTAL`=6, `V_ACTIVE`=3, `V_TOTAL`=6, `VS_LINES`=1, `V_START`=2, `CLK_DIV`=2), FIFO preloaded with 0x000001..0x00000C, `enable`=1.
   - Expect exactly 12 valid pixels, in order.
   - `vsync` high for the first 12 clk cycles of the frame.
   - `frame_done` after 72 clk cycles.
2. `CLK_DIV`=1, same raster: `clken` high every RUN cycle; 12 pops per frame; a second frame starts with no gap.
3. FIFO holds only 5 words.
   - Expect pixels 6..12 = 0 with `valid`=1, and no `fifo_rd_en` while `fifo_empty`=1.
   - `underflow` is 1 from pixel 6 and clears at the next frame start.
4. Drop `enable` mid-frame: the frame completes; `frame_done` fires; 1 DRAIN cycle; then IDLE with all outputs 0.
5. Assert `rst` during an active line: all outputs 0 next cycle; no pops; re-enable starts again at `v`=0 with `vsync`=1.
6. Default 640×480 raster: count 307200 valid pixels and 420000 `clken` pulses per frame.
